// File: rtl/kv_cache_seq.sv
// Sequencer between a command/write-data port and a 4x2x8x256x16-byte KV cache with 2-cycle read latency.
// Writes stream 16 dims at one position; reads sweep positions 0..P, 16 dims each, back out as a byte stream.
`timescale 1ns/1ps
module kv_cache_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_op_i,
  input  logic [1:0] cmd_layer_i,
  input  logic       cmd_kv_i,
  input  logic [2:0] cmd_head_i,
  input  logic [7:0] cmd_pos_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic [7:0] wr_data_i,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic [7:0] rd_pos_o,
  output logic [3:0] rd_dim_o,
  output logic       rd_last_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] kv_layer_o,
  output logic       kv_sel_o,
  output logic [2:0] kv_head_o,
  output logic [7:0] kv_pos_o,
  output logic [3:0] kv_dim_o,
  output logic       kv_we_o,
  output logic [7:0] kv_wdata_o,
  input  logic [7:0] kv_rdata_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t     r_state;
  logic       r_op;
  logic [1:0] r_layer;
  logic       r_kv;
  logic [2:0] r_head;
  logic [7:0] r_pos;
  logic [3:0] r_dim;
  logic [7:0] r_pcnt;
  logic       r_drain;
  logic       r_wdone;
  logic       r_v1, r_v2, r_l1, r_l2;
  logic [7:0] r_p1, r_p2;
  logic [3:0] r_d1, r_d2;

  logic w_issue;
  logic w_final;

  assign w_issue = (r_state == READ);
  // Equality on full 8-bit counters lets P=255 finish without needing a 9th bit.
  assign w_final = w_issue && (r_pcnt == r_pos) && (r_dim == 4'd15);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_op    <= 1'b0;
      r_layer <= 2'd0;
      r_kv    <= 1'b0;
      r_head  <= 3'd0;
      r_pos   <= 8'd0;
      r_dim   <= 4'd0;
      r_pcnt  <= 8'd0;
      r_drain <= 1'b0;
      r_wdone <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_l1    <= 1'b0;
      r_l2    <= 1'b0;
      r_p1    <= 8'd0;
      r_p2    <= 8'd0;
      r_d1    <= 4'd0;
      r_d2    <= 4'd0;
    end else begin
      r_wdone <= 1'b0;
      r_v1    <= w_issue;
      r_l1    <= w_final;
      r_p1    <= r_pcnt;
      r_d1    <= r_dim;
      r_v2    <= r_v1;
      r_l2    <= r_l1;
      r_p2    <= r_p1;
      r_d2    <= r_d1;
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_op    <= cmd_op_i;
            r_layer <= cmd_layer_i;
            r_kv    <= cmd_kv_i;
            r_head  <= cmd_head_i;
            r_pos   <= cmd_pos_i;
            r_dim   <= 4'd0;
            r_pcnt  <= 8'd0;
            r_state <= cmd_op_i ? READ : WRITE;
          end
        end
        WRITE: begin
          if (wr_valid_i) begin
            r_dim <= r_dim + 4'd1;
            if (r_dim == 4'd15) begin
              r_state <= IDLE;
              r_wdone <= 1'b1;
            end
          end
        end
        READ: begin
          r_dim <= r_dim + 4'd1;
          if (r_dim == 4'd15) r_pcnt <= r_pcnt + 8'd1;
          if (w_final) begin
            r_state <= DRAIN;
            r_drain <= 1'b0;
          end
        end
        DRAIN: begin
          // Two cycles here cover the cache latency so done lines up with the last byte.
          r_drain <= 1'b1;
          if (r_drain) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign wr_ready_o  = (r_state == WRITE);

  assign kv_layer_o = r_layer;
  assign kv_sel_o   = r_kv;
  assign kv_head_o  = r_head;
  assign kv_pos_o   = (r_state == WRITE) ? r_pos :
                      (r_state == READ)  ? r_pcnt : 8'd0;
  assign kv_dim_o   = ((r_state == WRITE) || (r_state == READ)) ? r_dim : 4'd0;
  assign kv_we_o    = (r_state == WRITE) && wr_valid_i;
  assign kv_wdata_o = (r_state == WRITE) ? wr_data_i : 8'd0;

  assign rd_valid_o = r_v2;
  assign rd_last_o  = r_v2 & r_l2;
  assign rd_pos_o   = r_p2;
  assign rd_dim_o   = r_d2;
  assign rd_data_o  = kv_rdata_i;

  assign done_o = r_wdone | (r_op & r_v2 & r_l2);

endmodule

// File: tb/tb_kv_cache_seq.sv
// Scoreboard bench for kv_cache_seq: stimulus pushes expected writes/beats/done pulses, a negedge monitor pops and compares.
// A behavioural cache returns a fixed function of the address after two cycles.
`timescale 1ns/1ps
module tb_kv_cache_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i, cmd_ready_o, cmd_op_i, cmd_kv_i;
  logic [1:0] cmd_layer_i;
  logic [2:0] cmd_head_i;
  logic [7:0] cmd_pos_i;
  logic       wr_valid_i, wr_ready_o;
  logic [7:0] wr_data_i;
  logic       rd_valid_o, rd_last_o;
  logic [7:0] rd_data_o, rd_pos_o;
  logic [3:0] rd_dim_o;
  logic       busy_o, done_o;
  logic [1:0] kv_layer_o;
  logic       kv_sel_o, kv_we_o;
  logic [2:0] kv_head_o;
  logic [7:0] kv_pos_o, kv_wdata_o, kv_rdata_i;
  logic [3:0] kv_dim_o;

  kv_cache_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_layer_i(cmd_layer_i), .cmd_kv_i(cmd_kv_i), .cmd_head_i(cmd_head_i), .cmd_pos_i(cmd_pos_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_pos_o(rd_pos_o), .rd_dim_o(rd_dim_o),
    .rd_last_o(rd_last_o), .busy_o(busy_o), .done_o(done_o),
    .kv_layer_o(kv_layer_o), .kv_sel_o(kv_sel_o), .kv_head_o(kv_head_o), .kv_pos_o(kv_pos_o),
    .kv_dim_o(kv_dim_o), .kv_we_o(kv_we_o), .kv_wdata_o(kv_wdata_o), .kv_rdata_i(kv_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [7:0] pos;
    logic [3:0] dim;
    logic [7:0] data;
    logic [1:0] layer;
    logic       sel;
    logic [2:0] head;
  } wrExp_t;

  typedef struct {
    int         cyc;
    logic [7:0] pos;
    logic [3:0] dim;
    logic [7:0] data;
    logic       last;
  } rdExp_t;

  wrExp_t expWr[$];
  rdExp_t expRd[$];
  int     expDone[$];
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  function automatic logic [7:0] cacheVal(input logic [1:0] l, input logic s, input logic [2:0] h,
                                          input logic [7:0] p, input logic [3:0] d);
    logic [7:0] r;
    r = p * 8'd7 + {4'd0, d} * 8'd13 + {6'd0, l} * 8'd3 + {7'd0, s} * 8'd5 + {5'd0, h};
    return r ^ 8'hA5;
  endfunction

  logic [7:0] cachePipe1, cachePipe2;
  always @(posedge clk_i) begin
    cachePipe1 <= cacheVal(kv_layer_o, kv_sel_o, kv_head_o, kv_pos_o, kv_dim_o);
    cachePipe2 <= cachePipe1;
  end
  assign kv_rdata_i = cachePipe2;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every DUT output event must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (kv_we_o) begin
        if (expWr.size() == 0) checkOutput("unexpected kv write", 64'({kv_pos_o, kv_dim_o}), 64'hFFFF);
        else begin
          wrExp_t e;
          e = expWr.pop_front();
          checkOutput("kv write", 64'({cyc, kv_pos_o, kv_dim_o, kv_wdata_o, kv_layer_o, kv_sel_o, kv_head_o}),
                      64'({e.cyc, e.pos, e.dim, e.data, e.layer, e.sel, e.head}));
        end
      end
      if (rd_valid_o) begin
        if (expRd.size() == 0) checkOutput("unexpected rd beat", 64'({rd_pos_o, rd_dim_o}), 64'hFFFF);
        else begin
          rdExp_t e;
          e = expRd.pop_front();
          checkOutput("rd beat", 64'({cyc, rd_pos_o, rd_dim_o, rd_data_o, rd_last_o}),
                      64'({e.cyc, e.pos, e.dim, e.data, e.last}));
        end
      end
      if (done_o) begin
        if (expDone.size() == 0) checkOutput("unexpected done", 64'(cyc), 64'hFFFF_FFFF);
        else checkOutput("done cycle", 64'(cyc), 64'(expDone.pop_front()));
      end
    end
  end

  // Presents a command and holds it until accepted; returns with cyc equal to the first busy cycle.
  task automatic applyStimulus(input logic op, input logic [1:0] layer, input logic kv, input logic [2:0] head,
                               input logic [7:0] pos, input int expAccept);
    int waited = 0;
    cmd_op_i = op; cmd_layer_i = layer; cmd_kv_i = kv; cmd_head_i = head; cmd_pos_i = pos;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && waited < 5000) begin
      waitCycle();
      waited++;
    end
    if (expAccept >= 0) checkOutput("accept cycle", 64'(cyc), 64'(expAccept));
    if (!cmd_ready_o) checkOutput("accept timeout", 64'(cmd_ready_o), 64'd1);
    waitCycle();
    cmd_valid_i = 1'b0;
    cmd_op_i = ~op;
    cmd_pos_i = 8'hEE;
  endtask

  task automatic writeCmd(input logic [1:0] layer, input logic kv, input logic [2:0] head, input logic [7:0] pos,
                          input logic [7:0] base, input bit gapped, input int expAccept);
    applyStimulus(1'b0, layer, kv, head, pos, expAccept);
    checkOutput("wr_ready in WRITE", 64'(wr_ready_o), 64'd1);
    for (int i = 0; i < 16; i++) begin
      wrExp_t e;
      wr_valid_i = 1'b1;
      wr_data_i  = base + 8'(i);
      e.cyc = cyc; e.pos = pos; e.dim = 4'(i); e.data = base + 8'(i);
      e.layer = layer; e.sel = kv; e.head = head;
      expWr.push_back(e);
      waitCycle();
      if (gapped && i < 15) begin
        wr_valid_i = 1'b0;
        wr_data_i  = 8'($urandom);
        waitCycle();
      end
    end
    expDone.push_back(cyc);
    wr_valid_i = 1'b0;
    wr_data_i  = 8'hCC;
    #1;
    checkOutput("busy after write", 64'(busy_o), 64'd0);
  endtask

  task automatic readCmd(input logic [1:0] layer, input logic kv, input logic [2:0] head, input logic [7:0] pos,
                         input bit waitDone, output int startCyc);
    int total;
    applyStimulus(1'b1, layer, kv, head, pos, -1);
    startCyc = cyc;
    total = 16 * (int'(pos) + 1);
    for (int p = 0; p <= int'(pos); p++)
      for (int d = 0; d < 16; d++) begin
        rdExp_t e;
        e.cyc = startCyc + 2 + 16 * p + d;
        e.pos = 8'(p); e.dim = 4'(d);
        e.data = cacheVal(layer, kv, head, 8'(p), 4'(d));
        e.last = (p == int'(pos)) && (d == 15);
        expRd.push_back(e);
      end
    expDone.push_back(startCyc + total + 1);
    if (waitDone) begin
      repeat (total + 1) waitCycle();
      checkOutput("busy at read done", 64'(busy_o), 64'd1);
      waitCycle();
      checkOutput("busy after read", 64'(busy_o), 64'd0);
      checkOutput("cmd_ready after read", 64'(cmd_ready_o), 64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_op_i = 1'b0; cmd_layer_i = 2'd0; cmd_kv_i = 1'b0; cmd_head_i = 3'd0; cmd_pos_i = 8'd0;
    wr_valid_i = 1'b0; wr_data_i = 8'd0;
    repeat (2) waitCycle();
    checkOutput("reset cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("reset busy", 64'(busy_o), 64'd0);
    checkOutput("reset done", 64'(done_o), 64'd0);
    checkOutput("reset rd_valid", 64'(rd_valid_o), 64'd0);
    checkOutput("reset wr_ready", 64'(wr_ready_o), 64'd0);
    checkOutput("reset kv addr", 64'({kv_pos_o, kv_dim_o, kv_we_o}), 64'd0);
    rst_i = 1'b0;
    waitCycle();

    writeCmd(2'd2, 1'b1, 3'd5, 8'd7, 8'h10, 1'b0, -1);
    writeCmd(2'd2, 1'b1, 3'd5, 8'd7, 8'h10, 1'b1, -1);
    waitCycle();
    readCmd(2'd2, 1'b1, 3'd5, 8'd0, 1'b1, a);
    readCmd(2'd3, 1'b0, 3'd7, 8'd255, 1'b1, a);

    // A write held against a busy read is only taken in the first IDLE cycle (start + 18).
    readCmd(2'd0, 1'b1, 3'd2, 8'd0, 1'b0, a);
    checkOutput("cmd_ready while busy", 64'(cmd_ready_o), 64'd0);
    writeCmd(2'd1, 1'b0, 3'd3, 8'd9, 8'h40, 1'b0, a + 18);

    readCmd(2'd1, 1'b1, 3'd6, 8'd5, 1'b0, a);
    repeat (56) waitCycle();
    checkOutput("pre-reset issue addr", 64'({kv_pos_o, kv_dim_o}), 64'({8'd3, 4'd8}));
    expRd.delete();
    expDone.delete();
    rst_i = 1'b1;
    #1;
    checkOutput("rd_valid on reset", 64'(rd_valid_o), 64'd0);
    checkOutput("cmd_ready on reset", 64'(cmd_ready_o), 64'd1);
    checkOutput("busy on reset", 64'(busy_o), 64'd0);
    repeat (2) waitCycle();
    rst_i = 1'b0;
    repeat (20) waitCycle();

    writeCmd(2'd3, 1'b0, 3'd1, 8'd200, 8'hF8, 1'b1, -1);
    readCmd(2'd3, 1'b0, 3'd1, 8'd1, 1'b1, a);
    repeat (4) waitCycle();

    checkOutput("pending writes", 64'(expWr.size()), 64'd0);
    checkOutput("pending beats", 64'(expRd.size()), 64'd0);
    checkOutput("pending done", 64'(expDone.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kv_cache_seq.md
KV_CACHE_SEQ -- requirements
Module: kv_cache_seq

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 4 layers, 8 heads, 256 positions and 16 dims.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have the command ports cmd_valid_i (in, 1), cmd_ready_o (out, 1), cmd_op_i (in, 1; 0=write, 1=read), cmd_layer_i (in, 2), cmd_kv_i (in, 1; 0=K, 1=V), cmd_head_i (in, 3) and cmd_pos_i (in, 8).
REQ-005 SHALL have the write-data ports wr_valid_i (in, 1), wr_ready_o (out, 1) and wr_data_i (in, 8).
REQ-006 SHALL have the read-stream ports rd_valid_o (out, 1), rd_data_o (out, 8), rd_pos_o (out, 8), rd_dim_o (out, 4) and rd_last_o (out, 1).
REQ-007 SHALL have the status ports busy_o (out, 1) and done_o (out, 1; single-cycle pulse).
REQ-008 SHALL have the cache-side ports kv_layer_o (out, 2), kv_sel_o (out, 1), kv_head_o (out, 3), kv_pos_o (out, 8), kv_dim_o (out, 4), kv_we_o (out, 1), kv_wdata_o (out, 8) and kv_rdata_i (in, 8); the attached cache has a 2-cycle read latency.

Function
REQ-009 SHALL implement the FSM states IDLE, WRITE, READ and DRAIN.
REQ-010 SHALL drive cmd_ready_o = (state==IDLE); a command is accepted on cmd_valid_i & cmd_ready_o, and its layer, kv, head, pos and op fields are latched.
REQ-011 SHALL transition IDLE->WRITE on an accepted op=0 command and IDLE->READ on an accepted op=1 command; the dim counter and the pos counter both clear to 0.
REQ-012 SHALL drive busy_o = (state!=IDLE).
REQ-013 SHALL drive kv_layer_o, kv_sel_o and kv_head_o from the latched fields, combinationally, in every state.
REQ-014 SHALL, in WRITE, drive wr_ready_o=1, kv_pos_o = the latched pos, kv_dim_o = the dim counter, kv_we_o = wr_valid_i and kv_wdata_o = wr_data_i.
REQ-015 SHALL, in WRITE, increment the dim counter on each cycle with wr_valid_i=1; a wr_valid_i=0 cycle stalls with kv_we_o=0.
REQ-016 SHALL, when the beat at dim 15 is accepted, go WRITE->IDLE and pulse done_o in the next cycle; exactly 16 bytes are written per write command.
REQ-017 SHALL drive wr_ready_o=0 outside WRITE; wr_data_i is ignored there.
REQ-018 SHALL drive kv_we_o=0 in every state except WRITE.
REQ-019 SHALL, in READ, issue one read per cycle with kv_pos_o = the pos counter and kv_dim_o = the dim counter; dim runs 0..15 and then wraps, and pos increments on each dim wrap.
REQ-020 SHALL stop issuing after the final issue (pos = latched pos, dim=15) and go READ->DRAIN; a read command issues exactly 16*(P+1) reads, where P = the latched pos.
REQ-021 SHALL use 8-bit counters compared for equality, so that P=255 completes without overflow.
REQ-022 SHALL carry valid, pos, dim and last through a 2-stage pipeline, so that rd_valid_o asserts exactly 2 cycles after the corresponding issue.
REQ-023 SHALL drive rd_data_o = kv_rdata_i, rd_pos_o/rd_dim_o = the issued address, and rd_last_o=1 only on the final byte.
REQ-024 SHALL keep the read stream free of backpressure; the consumer must accept one byte per cycle.
REQ-025 SHALL stay in DRAIN for exactly 2 cycles and then return to IDLE; done_o pulses in the same cycle as rd_last_o.
REQ-026 SHALL, in IDLE and DRAIN, drive kv_pos_o=0 and kv_dim_o=0.
REQ-027 SHALL ignore cmd_valid_i while busy; a new command is accepted at the earliest in the cycle after done_o for a read, or in the cycle done_o is high for a write.
REQ-028 SHALL drive rd_valid_o, rd_last_o and done_o to 0 whenever not explicitly asserted.

Reset
REQ-029 SHALL, on rst_i=1 (asynchronous), force state=IDLE, clear all counters, latched fields and pipeline valid/last bits to 0, and drive done_o=0, busy_o=0 and cmd_ready_o=1.
REQ-030 SHALL abort any operation in progress when reset is asserted mid-operation, with no rd_valid_o or kv_we_o after reset release until a new command arrives.

Verification
REQ-031 Write layer=2, kv=1, head=5, pos=7, with bytes 0x10..0x1F sent with no gaps -> 16 kv_we_o cycles at pos 7, dims 0..15, with data matching; done_o fires 1 cycle after the last beat.
REQ-032 The same write with wr_valid_i low every other cycle -> still exactly 16 writes, in order, and no kv_we_o during the gaps.
REQ-033 Read pos=0 against a cache model -> 16 rd_valid_o beats starting 2 cycles after the first issue, with rd_last_o and done_o on beat 16 and busy_o falling the next cycle.
REQ-034 Read pos=255 -> 4096 contiguous beats, rd_pos_o running 0..255, a single rd_last_o, and the FSM ending in IDLE.
REQ-035 Issue a command while busy -> the command is not accepted; it is accepted once the FSM returns to IDLE.
REQ-036 Assert rst_i during a READ at pos 3, dim 8 -> rd_valid_o drops immediately, with no further beats and cmd_ready_o=1.
